div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//   Shares one iterative 32-bit unsigned divider among NREQ requesters.
//   Arbitrates requests round-robin, latches operands, pulses the divider's start,
//   waits for its finish and returns the result with the requester id.
//   Uses valid/ready on both sides. Adds a divide-by-zero flag and a watchdog timeout.
//   Sits between the requesting units and the single shared divider instance.
// PARAMETERS
//   NREQ     2   number of requesters, 2..8
//   IDW      1   id width, clog2(NREQ) (min 1)
//   TIMEOUT  64  max cycles in WAIT before an error response is forced
// PORTS
//   clk           in   1          clock, all state on rising edge
//   rst           in   1          asynchronous, active-low reset
//   req_valid     in   NREQ       per-requester request valid
//   req_ready     out  NREQ       per-requester accept, one-hot or zero
//   req_dividend  in   32*NREQ    flattened; requester i owns bits [32i+31:32i]
//   req_divisor   in   32*NREQ    flattened, same packing
//   rsp_valid     out  1          response valid
//   rsp_ready     in   1          response consumer ready
//   rsp_id        out  IDW        index of the requester being answered
//   rsp_quotient  out  32         quotient
//   rsp_remainder out  32         remainder
//   rsp_divzero   out  1          latched divisor was 0
//   rsp_err       out  1          watchdog expired, result invalid
//   div_start     out  1          one-cycle start pulse to divider
//   div_dividend  out  32         operand, held stable from ISSUE to next accept
//   div_divisor   out  32         operand, held stable, same window
//   div_quotient  in   32         divider quotient
//   div_remainder in   32         divider remainder
//   div_finish    in   1          divider done (level; may stay high between ops)
//   busy          out  1          state != IDLE
// BEHAVIOUR
//   Reset (async, rst=0):
//     - state=IDLE, rr_ptr=0, wdog=0.
//     - All outputs 0; the operand/result registers clear to 0.
//     - Abandons any in-flight op; the divider shares the same reset source.
//   States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE:
//     - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready[grant]=1 combinationally; req_ready=0 in every other state.
//     - On valid&ready: latch operands and id, set rr_ptr=(grant+1) mod NREQ, go to ISSUE.
//     - No request valid: stay in IDLE, rr_ptr unchanged.
//   ISSUE: div_start=1 for exactly this cycle; wdog=0; go to WAIT.
//   WAIT:
//     - div_finish is ignored until WAIT is entered.
//     - This discards a stale finish level from the previous op.
//     - On div_finish=1: capture div_quotient/div_remainder.
//       Set rsp_divzero=(latched divisor==0), rsp_err=0, rsp_valid=1, go to RESP.
//     - Else wdog++. At wdog==TIMEOUT-1: set rsp_err=1, q=r=0, rsp_valid=1, go to RESP.
//   RESP:
//     - rsp_* hold stable while rsp_valid && !rsp_ready.
//     - On rsp_ready: rsp_valid=0, go to IDLE.
//     - A new grant is possible in the next cycle; no accept in the same cycle.
//   Latency, from accept edge to rsp_valid high, with the paired divider:
//     - normal op: 35 cycles.
//     - divisor==0 or dividend<divisor: 3 cycles.
//   Throughput: one op in flight; back-to-back ops need >=1 IDLE cycle between them.
//   A requester that drops req_valid before acceptance is never granted.
// TESTING
//   1. Req0 100/7, rsp_ready=1 -> rsp at +35 cyc: id=0, q=14, r=2, divzero=0, err=0.
//   2. Req0 and req1 valid continuously (r1: 9/3) from reset.
//      Grants alternate 0,1,0,1 and each transfer carries the correct id.
//   3. Req1 5/0 -> +3 cyc: q=0, r=0, divzero=1; then req1 3/10 -> +3 cyc: q=0, r=3.
//   4. Hold rsp_ready=0 for 10 cyc after rsp_valid.
//      Response stays stable, no new req_ready, accepted on the first ready cycle.
//   5. Tie div_finish=0 -> rsp_err=1 after TIMEOUT cycles in WAIT; FSM back in IDLE.
//   6. Assert rst=0 mid-WAIT.
//      Outputs go 0 immediately; the next 0xFFFFFFFF/1 completes as q=0xFFFFFFFF, r=0.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one iterative 32-bit divider among NREQ requesters,
// with divide-by-zero flag and a watchdog that forces an error response.
module div_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_dividend,
    input  logic [32*NREQ-1:0]   req_divisor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_quotient,
    output logic [31:0]          rsp_remainder,
    output logic                 rsp_divzero,
    output logic                 rsp_err,
    output logic                 div_start,
    output logic [31:0]          div_dividend,
    output logic [31:0]          div_divisor,
    input  logic [31:0]          div_quotient,
    input  logic [31:0]          div_remainder,
    input  logic                 div_finish,
    output logic                 busy
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr, r_id, w_grant, w_ptr_nxt;
    logic [WDW-1:0]  r_wdog;
    logic [31:0]     r_dividend, r_divisor, r_quotient, r_remainder;
    logic            r_rsp_valid, r_divzero, r_err;
    logic            w_found, w_accept, w_timeout, w_done;
    logic [IDW:0]    w_idx;
    logic [31:0]     w_dvd [NREQ];
    logic [31:0]     w_dvs [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_dvd[g] = req_dividend[32*g +: 32];
        assign w_dvs[g] = req_divisor[32*g +: 32];
    end

    // Scan starts at rr_ptr and wraps; the sum fits in IDW+1 bits before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[IDW-1:0];
            end
        end
    end

    assign w_accept  = rst && r_state == S_IDLE && w_found;
    assign req_ready = w_accept ? NREQ'(1) << w_grant : '0;
    assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_timeout = r_wdog == WDW'(TIMEOUT - 1);
    assign w_done    = r_state == S_WAIT && (div_finish || w_timeout);

    always_comb begin
        w_state_nxt = (r_state == S_IDLE && w_accept)  ? S_ISSUE :
                      (r_state == S_ISSUE)             ? S_WAIT  :
                      w_done                           ? S_RESP  :
                      (r_state == S_RESP && rsp_ready) ? S_IDLE  : r_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_wdog      <= '0;
            r_rsp_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divzero   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dividend <= w_dvd[w_grant];
                r_divisor  <= w_dvs[w_grant];
                r_id       <= w_grant;
                r_rr_ptr   <= w_ptr_nxt;
            end
            if (r_state == S_ISSUE) r_wdog <= '0;
            else if (r_state == S_WAIT && !div_finish) r_wdog <= r_wdog + 1'b1;
            // A real finish wins over a watchdog expiring in the same cycle.
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_quotient  <= div_finish ? div_quotient : '0;
                r_remainder <= div_finish ? div_remainder : '0;
                r_divzero   <= div_finish && r_divisor == '0;
                r_err       <= !div_finish;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_quotient  = r_quotient;
    assign rsp_remainder = r_remainder;
    assign rsp_divzero   = r_divzero;
    assign rsp_err       = r_err;
    assign div_start     = r_state == S_ISSUE;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign busy          = r_state != S_IDLE;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural iterative divider
// (1 cycle for trivial cases, 33 cycles otherwise; finish level held until next start).
module tb_div_arbiter;
    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_dividend, req_divisor;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_quotient, rsp_remainder;
    logic                rsp_divzero, rsp_err;
    logic                div_start;
    logic [31:0]         div_dividend, div_divisor;
    logic [31:0]         div_quotient, div_remainder;
    logic                div_finish;
    logic                busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic tie_finish_low = 1'b0;

    div_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_divzero(rsp_divzero), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finish(div_finish), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural divider sharing the arbiter's reset.
    logic [5:0]  m_cnt;
    logic        m_fin;
    logic [31:0] m_q, m_r;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= '0; m_fin <= 1'b0; m_q <= '0; m_r <= '0;
        end else if (div_start) begin
            m_fin <= 1'b0;
            m_cnt <= (div_divisor == 0 || div_dividend < div_divisor) ? 6'd1 : 6'd33;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 6'd1;
            if (m_cnt == 6'd1) begin
                m_fin <= 1'b1;
                m_q   <= (div_divisor == 0) ? 32'd0 : div_dividend / div_divisor;
                m_r   <= (div_divisor == 0) ? 32'd0 : div_dividend % div_divisor;
            end
        end
    end
    assign div_finish    = m_fin && !tie_finish_low;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic apply_reset();
        rst = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one request and measures cycles from the accept edge to rsp_valid.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [IDW-1:0] g_id, output logic [31:0] g_q,
                          output logic [31:0] g_r, output logic g_dz, output logic g_err);
        bit acc = 0;
        @(negedge clk);
        req_dividend[32*id +: 32] = a;
        req_divisor[32*id +: 32]  = b;
        req_valid[id] = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            #1;
            if (req_ready[id]) begin
                @(posedge clk);
                #1;
                req_valid[id] = 1'b0;
                acc = 1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid[id] = 1'b0;
        lat = -1;
        if (acc) begin
            lat = 0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk);
                #1;
                lat++;
                if (rsp_valid) break;
            end
        end
        g_id = rsp_id; g_q = rsp_quotient; g_r = rsp_remainder; g_dz = rsp_divzero; g_err = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, div_start, busy, rsp_err, rsp_divzero} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {rsp_valid, req_ready, div_start, busy, rsp_err, rsp_divzero});
        end
        n_cmp++;
        if ({div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                     div_dividend, div_divisor, rsp_quotient, rsp_remainder);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        int lat; logic [IDW-1:0] id; logic [31:0] q, r; logic dz, er;
        run_op(0, 32'd100, 32'd7, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== 35) begin n_fail++; $display("FAIL t1_latency: got %0d expected 35", lat); end
        n_cmp++;
        if ({id, q, r, dz, er} !== {1'b0, 32'd14, 32'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_result: got id=%0d q=%0d r=%0d dz=%b err=%b expected 0/14/2/0/0",
                     id, q, r, dz, er);
        end
    endtask

    task automatic test_divzero_small();
        int lat; logic [IDW-1:0] id; logic [31:0] q, r; logic dz, er;
        run_op(1, 32'd5, 32'd0, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL t3_dz_latency: got %0d expected 3", lat); end
        n_cmp++;
        if ({id, q, r, dz, er} !== {1'b1, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL t3_dz_result: got id=%0d q=%0d r=%0d dz=%b err=%b expected 1/0/0/1/0",
                     id, q, r, dz, er);
        end
        run_op(1, 32'd3, 32'd10, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL t3_small_latency: got %0d expected 3", lat); end
        n_cmp++;
        if ({id, q, r, dz, er} !== {1'b1, 32'd0, 32'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t3_small_result: got id=%0d q=%0d r=%0d dz=%b err=%b expected 1/0/3/0/0",
                     id, q, r, dz, er);
        end
    endtask

    task automatic test_back_to_back();
        int grants[4]; int ids[4]; logic [31:0] qs[4]; logic [31:0] rs[4];
        int ng = 0, nr = 0;
        apply_reset();
        req_dividend = {32'd9, 32'd100};
        req_divisor  = {32'd3, 32'd7};
        req_valid    = 2'b11;
        for (int c = 0; c < 400 && nr < 4; c++) begin
            #1;
            if (req_ready != 0) begin
                if (ng < 4) grants[ng] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
                ng++;
            end
            if (rsp_valid) begin
                if (nr < 4) begin ids[nr] = int'(rsp_id); qs[nr] = rsp_quotient; rs[nr] = rsp_remainder; end
                nr++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        n_cmp++;
        if (ng !== 4 || nr !== 4) begin
            n_fail++;
            $display("FAIL t2_count: got %0d grants %0d responses expected 4/4", ng, nr);
        end
        for (int i = 0; i < 4 && i < nr && i < ng; i++) begin
            n_cmp++;
            if (grants[i] !== i % 2 || ids[i] !== i % 2) begin
                n_fail++;
                $display("FAIL t2_order[%0d]: got grant=%0d id=%0d expected %0d", i, grants[i], ids[i], i % 2);
            end
            n_cmp++;
            if (qs[i] !== ((i % 2) ? 32'd3 : 32'd14) || rs[i] !== ((i % 2) ? 32'd0 : 32'd2)) begin
                n_fail++;
                $display("FAIL t2_data[%0d]: got q=%0d r=%0d", i, qs[i], rs[i]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        int lat; logic [IDW-1:0] id; logic [31:0] q, r; logic dz, er;
        int bad = 0;
        rsp_ready = 1'b0;
        run_op(0, 32'd100, 32'd7, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== 35 || q !== 32'd14) begin
            n_fail++;
            $display("FAIL t4_first: got lat=%0d q=%0d expected 35/14", lat, q);
        end
        req_dividend[63:32] = 32'd9;
        req_divisor[63:32]  = 32'd3;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_quotient !== 32'd14 || rsp_remainder !== 32'd2 ||
                rsp_id !== 1'b0 || req_ready !== 2'b00) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL t4_hold: got %0d unstable cycles expected 0", bad);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t4_release: got rsp_valid=%b expected 0", rsp_valid); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL t4_regrant: got %b expected 10", req_ready); end
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_dropped: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int lat; logic [IDW-1:0] id; logic [31:0] q, r; logic dz, er;
        tie_finish_low = 1'b1;
        run_op(0, 32'd10, 32'd2, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL t5_latency: got %0d expected %0d", lat, TIMEOUT + 1);
        end
        n_cmp++;
        if ({q, r, dz, er} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL t5_result: got q=%0d r=%0d dz=%b err=%b expected 0/0/0/1", q, r, dz, er);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_idle: got busy=%b rsp_valid=%b expected 0/0", busy, rsp_valid);
        end
        tie_finish_low = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [IDW-1:0] id; logic [31:0] q, r; logic dz, er;
        @(negedge clk);
        req_dividend[31:0] = 32'd100;
        req_divisor[31:0]  = 32'd7;
        req_valid[0] = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t6_grant: got %b expected 01", req_ready); end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || div_dividend !== 32'd100) begin
            n_fail++;
            $display("FAIL t6_inflight: got busy=%b dvd=%0d expected 1/100", busy, div_dividend);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, div_start, req_ready, div_dividend, div_divisor} !== '0) begin
            n_fail++;
            $display("FAIL t6_async: got busy=%b dvd=%h dvs=%h expected 0", busy, div_dividend, div_divisor);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(0, 32'hFFFF_FFFF, 32'd1, lat, id, q, r, dz, er);
        n_cmp++;
        if (lat !== 35 || {id, q, r, dz, er} !== {1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t6_after: got lat=%0d q=%h r=%h dz=%b err=%b expected 35/ffffffff/0/0/0",
                     lat, q, r, dz, er);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divzero_small();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
